// File: rtl/md_scheduler_if.sv
// Bundle of the E-stage multiply/divide request, D-stage hazard query and HI/LO results.
interface md_scheduler_if;
  logic [3:0]  E_mdop;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_md_use;
  logic [31:0] E_md_out;
  logic        busy;
  logic        D_md_stall;
  logic [31:0] HI;
  logic [31:0] LO;

  modport master (
    output E_mdop, E_A, E_B, D_md_use,
    input  E_md_out, busy, D_md_stall, HI, LO
  );

  modport slave (
    input  E_mdop, E_A, E_B, D_md_use,
    output E_md_out, busy, D_md_stall, HI, LO
  );
endinterface

// File: rtl/md_scheduler.sv
// Multi-cycle multiply/divide unit owning HI/LO, with a D-stage stall request
// raised while an operation is starting or running.
module md_scheduler #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic           clk,
  input logic           reset,
  md_scheduler_if.slave md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]    state;
  logic [CW-1:0] cnt;
  logic [3:0]    op_q;
  logic [31:0]   a_q, b_q;
  logic [31:0]   hi_q, lo_q;

  logic          start;
  logic [31:0]   res_hi, res_lo;
  logic          res_wr;

  logic [63:0]   prod_s, prod_u;
  logic          div_signed, a_neg, b_neg;
  logic [31:0]   a_mag, b_mag, q_mag, r_mag;

  assign start = (state == IDLE) && (md.E_mdop >= 4'd1) && (md.E_mdop <= 4'd4);

  // Signed divide is done on magnitudes and the signs re-applied, so the
  // -2^31 / -1 case wraps cleanly instead of overflowing a signed divider.
  always_comb begin
    prod_s     = {{32{a_q[31]}}, a_q} * {{32{b_q[31]}}, b_q};
    prod_u     = {32'd0, a_q} * {32'd0, b_q};
    div_signed = (op_q == 4'd3);
    a_neg      = div_signed & a_q[31];
    b_neg      = div_signed & b_q[31];
    a_mag      = a_neg ? -a_q : a_q;
    b_mag      = b_neg ? -b_q : b_q;
    q_mag      = '0;
    r_mag      = '0;
    if (b_mag != '0) begin
      q_mag = a_mag / b_mag;
      r_mag = a_mag % b_mag;
    end
    res_hi = hi_q;
    res_lo = lo_q;
    res_wr = 1'b0;
    case (op_q)
      4'd1: begin
        {res_hi, res_lo} = prod_s;
        res_wr           = 1'b1;
      end
      4'd2: begin
        {res_hi, res_lo} = prod_u;
        res_wr           = 1'b1;
      end
      4'd3, 4'd4: begin
        res_lo = (a_neg ^ b_neg) ? -q_mag : q_mag;
        res_hi = a_neg ? -r_mag : r_mag;
        res_wr = (b_q != '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            op_q  <= md.E_mdop;
            a_q   <= md.E_A;
            b_q   <= md.E_B;
            cnt   <= (md.E_mdop <= 4'd2) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            state <= RUN;
          end else if (md.E_mdop == 4'd5) begin
            hi_q <= md.E_A;
          end else if (md.E_mdop == 4'd6) begin
            lo_q <= md.E_A;
          end
        end
        default: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state <= IDLE;
            if (res_wr) begin
              hi_q <= res_hi;
              lo_q <= res_lo;
            end
          end
        end
      endcase
    end
  end

  assign md.busy       = (state == RUN);
  assign md.D_md_stall = md.D_md_use && (start || (state == RUN));
  assign md.HI         = hi_q;
  assign md.LO         = lo_q;
  assign md.E_md_out   = (md.E_mdop == 4'd7) ? hi_q :
                         (md.E_mdop == 4'd8) ? lo_q : '0;

endmodule

// File: tb/tb_md_scheduler.sv
// Randomized and directed bench for md_scheduler against a cycle-level reference model.
module tb_md_scheduler;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic clk;
  logic reset;

  md_scheduler_if mif ();

  md_scheduler #(
    .MULT_CYCLES(MC),
    .DIV_CYCLES (DC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .md   (mif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: remaining busy cycles, pending operation, HI/LO.
  int          m_left;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b, m_hi, m_lo;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_left = 0;
    m_op   = '0;
    m_a    = '0;
    m_b    = '0;
    m_hi   = '0;
    m_lo   = '0;
  endtask

  task automatic model_complete();
    int          sa, sb;
    longint      p, q, r;
    longint unsigned pu;
    sa = m_a;
    sb = m_b;
    case (m_op)
      4'd1: begin
        p    = longint'(sa) * longint'(sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      4'd2: begin
        pu   = longint'(m_a) * longint'(m_b);
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      4'd3: if (m_b != 0) begin
        q    = longint'(sa) / longint'(sb);
        r    = longint'(sa) % longint'(sb);
        m_lo = q[31:0];
        m_hi = r[31:0];
      end
      4'd4: if (m_b != 0) begin
        m_lo = m_a / m_b;
        m_hi = m_a % m_b;
      end
      default: ;
    endcase
  endtask

  // One cycle: drive at the falling edge, check outputs, then predict the next rising edge.
  task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic use_md, input logic rst);
    logic        m_start;
    logic [31:0] exp_out;
    @(negedge clk);
    mif.E_mdop   = op;
    mif.E_A      = a;
    mif.E_B      = b;
    mif.D_md_use = use_md;
    reset        = rst;
    if (rst) model_clear();
    #1;
    m_start = (m_left == 0) && (op >= 4'd1) && (op <= 4'd4);
    exp_out = (op == 4'd7) ? m_hi : (op == 4'd8) ? m_lo : 32'd0;
    check_eq("busy",   {31'd0, mif.busy},       {31'd0, m_left > 0});
    check_eq("stall",  {31'd0, mif.D_md_stall}, {31'd0, use_md && (m_start || m_left > 0)});
    check_eq("md_out", mif.E_md_out, exp_out);
    check_eq("hi",     mif.HI, m_hi);
    check_eq("lo",     mif.LO, m_lo);
    if (!rst) begin
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) model_complete();
      end else if (m_start) begin
        m_op   = op;
        m_a    = a;
        m_b    = b;
        m_left = (op <= 4'd2) ? MC : DC;
      end else if (op == 4'd5) begin
        m_hi = a;
      end else if (op == 4'd6) begin
        m_lo = a;
      end
    end
  endtask

  task automatic idle_steps(input int n, input logic use_md);
    for (int i = 0; i < n; i++) step(4'd0, $urandom, $urandom, use_md, 1'b0);
  endtask

  function automatic logic [31:0] rand_val();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    model_clear();
    reset        = 1'b1;
    mif.E_mdop   = '0;
    mif.E_A      = '0;
    mif.E_B      = '0;
    mif.D_md_use = 1'b0;

    // Reset state; start is still visible to the stall path while in reset.
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    step(4'd1, 32'd3, 32'd4, 1'b1, 1'b1);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    // Signed multiply.
    step(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0);
    idle_steps(MC + 1, 1'b0);
    check_eq("mult_hi", mif.HI, 32'hFFFF_FFFF);
    check_eq("mult_lo", mif.LO, 32'hFFFF_FFFA);

    // Unsigned multiply.
    step(4'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0);
    idle_steps(MC + 1, 1'b0);
    check_eq("multu_hi", mif.HI, 32'h0000_0001);
    check_eq("multu_lo", mif.LO, 32'hFFFF_FFFE);

    // Signed divide, then divide by zero leaves HI/LO alone.
    step(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    idle_steps(DC + 1, 1'b0);
    check_eq("div_lo", mif.LO, 32'hFFFF_FFFD);
    check_eq("div_hi", mif.HI, 32'hFFFF_FFFF);
    step(4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
    idle_steps(DC + 1, 1'b0);
    check_eq("divu0_lo", mif.LO, 32'hFFFF_FFFD);
    check_eq("divu0_hi", mif.HI, 32'hFFFF_FFFF);

    // Stall across a multiply with D_md_use held, then mfhi reads the new HI.
    step(4'd1, 32'd1000, 32'd7, 1'b1, 1'b0);
    idle_steps(MC, 1'b1);
    step(4'd7, 32'd0, 32'd0, 1'b1, 1'b0);
    check_eq("mfhi_after_mult", mif.E_md_out, 32'd0);
    check_eq("stall_after_busy", {31'd0, mif.D_md_stall}, 32'd0);

    // mthi during RUN is dropped; in IDLE it lands and mfhi sees it next cycle.
    step(4'd1, 32'd2, 32'd3, 1'b0, 1'b0);
    step(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    step(4'd6, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    idle_steps(MC - 1, 1'b0);
    check_eq("mthi_in_run", mif.HI, 32'd0);
    check_eq("mult_small_lo", mif.LO, 32'd6);
    step(4'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
    check_eq("mthi_no_bypass", mif.HI, 32'd0);
    step(4'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    check_eq("mthi_idle", mif.E_md_out, 32'h1234_5678);

    // Reset in the 3rd busy cycle of a divide aborts it; a new multiply then runs.
    step(4'd3, 32'd100, 32'd7, 1'b0, 1'b0);
    idle_steps(2, 1'b0);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check_eq("rst_busy", {31'd0, mif.busy}, 32'd0);
    check_eq("rst_hi", mif.HI, 32'd0);
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    idle_steps(DC, 1'b0);
    check_eq("rst_no_write_lo", mif.LO, 32'd0);
    step(4'd1, 32'd9, 32'd9, 1'b0, 1'b0);
    idle_steps(MC + 1, 1'b0);
    check_eq("post_rst_mult_lo", mif.LO, 32'd81);

    // Randomized traffic, including occasional resets and mid-run requests.
    for (int i = 0; i < 3000; i++) begin
      step(4'($urandom_range(0, 15)), rand_val(), rand_val(),
           1'($urandom_range(0, 1)), ($urandom_range(0, 199) == 0));
    end
    step(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/md_scheduler.md
MD_SCHEDULER -- requirements
Module: md_scheduler

Interface
REQ-001 Parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 Parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 clk  input  1  single system clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 E_mdop  input  4  E-stage MD operation: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 mfhi, 8 mflo; 9-15 treated as none.
REQ-006 E_A  input  32  forwarded rs value of E-stage instruction.
REQ-007 E_B  input  32  forwarded rt value of E-stage instruction.
REQ-008 D_md_use  input  1  D-stage instruction is any MD operation (codes 1-8).
REQ-009 E_md_out  output  32  HI for mfhi, LO for mflo, else 0.
REQ-010 busy  output  1  multi-cycle operation in progress.
REQ-011 D_md_stall  output  1  stall request to the hazard unit for the D stage.
REQ-012 HI  output  32  architectural HI register.
REQ-013 LO  output  32  architectural LO register.

Function
REQ-014 The block SHALL implement states IDLE and RUN plus a down-counter cnt sized for max(MULT_CYCLES, DIV_CYCLES).
REQ-015 start SHALL be asserted when E_mdop is 1-4 and state is IDLE; start is internal and combinational.
REQ-016 On an edge with start, the block SHALL latch E_mdop, E_A and E_B into operand registers, load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN.
REQ-017 busy SHALL equal (state == RUN), rising on the edge after start and staying high for exactly MULT_CYCLES or DIV_CYCLES cycles.
REQ-018 In RUN, cnt SHALL decrement every edge; on the edge where cnt==1, HI/LO SHALL be written with the result and the state SHALL return to IDLE.
REQ-019 mult: {HI,LO} = signed 64-bit product; multu: unsigned product.
REQ-020 div: LO = signed quotient truncated toward zero, HI = remainder carrying the dividend's sign; divu: unsigned quotient and remainder.
REQ-021 Division with latched divisor 0 SHALL run full DIV_CYCLES and then leave HI and LO unchanged.
REQ-022 mthi/mtlo SHALL write E_A to HI/LO on the next edge when state is IDLE; in RUN they SHALL be ignored.
REQ-023 E_md_out SHALL be combinational from the current HI/LO registers, without bypass of a same-cycle mthi/mtlo.
REQ-024 D_md_stall SHALL equal D_md_use && (start || busy).
REQ-025 Any E_mdop 1-6 arriving while in RUN SHALL be ignored; state, cnt, operands and HI/LO are unaffected.
REQ-026 Operand registers SHALL hold during RUN regardless of E_A/E_B changes.
REQ-027 All multiply/divide arithmetic SHALL be on 32-bit operands with 64-bit intermediate; no other width extension.

Reset
REQ-028 While reset is high, state SHALL be IDLE, cnt 0, operand registers 0, HI 0, LO 0, busy 0, D_md_stall = D_md_use && start.
REQ-029 Reset asserted mid-RUN SHALL abort the operation immediately, without any HI/LO write.
REQ-030 After reset deasserts, the first edge with start SHALL begin a new operation normally.

Verification
REQ-031 mult, E_A=0xFFFFFFFE (-2), E_B=3 -> busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-032 multu, E_A=0xFFFFFFFF, E_B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 div, E_A=-7, E_B=2 -> busy 10 cycles; then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1); divu, E_A=7, E_B=0 -> after 10 cycles HI/LO unchanged.
REQ-034 mult start with D_md_use=1 held -> D_md_stall high in the start cycle and all 5 busy cycles, low the cycle after busy falls; mfhi then reads the new HI.
REQ-035 mthi E_A=0x12345678 issued during RUN -> HI unaffected; issued in IDLE -> HI=0x12345678 on the next edge, and mfhi in the following cycle returns it.
REQ-036 Reset pulsed in the 3rd cycle of a div -> busy=0 immediately, HI=LO=0, no later write; a new mult then completes in 5 cycles.
